// File: rtl/id_ex_stage_if.sv
// ID -> EX stage bundle: decoded instruction from ID, the ID/EX register
// contents toward forwarding/EX, and the stall back toward PC/IF_ID.
interface id_ex_stage_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
);
    logic [4:0]        IF_ID_RegisterRn1;
    logic [4:0]        IF_ID_RegisterRm2;
    logic [4:0]        IF_ID_RegisterRd;
    logic              IF_ID_UsesRm;
    logic [DATA_W-1:0] ID_ReadData1;
    logic [DATA_W-1:0] ID_ReadData2;
    logic [DATA_W-1:0] ID_SignExtImm;
    logic [1:0]        ID_ALUOp;
    logic              ID_ALUSrc;
    logic              ID_MemRead;
    logic              ID_MemWrite;
    logic              ID_RegWrite;
    logic              ID_MemtoReg;
    logic              ID_Branch;
    logic              Flush;

    logic              Stall;
    logic              ID_EX_Valid;
    logic [4:0]        ID_EX_RegisterRn1;
    logic [4:0]        ID_EX_RegisterRm2;
    logic [4:0]        ID_EX_RegisterRd;
    logic [DATA_W-1:0] ID_EX_ReadData1;
    logic [DATA_W-1:0] ID_EX_ReadData2;
    logic [DATA_W-1:0] ID_EX_SignExtImm;
    logic [1:0]        ID_EX_ALUOp;
    logic              ID_EX_ALUSrc;
    logic              ID_EX_MemRead;
    logic              ID_EX_MemWrite;
    logic              ID_EX_RegWrite;
    logic              ID_EX_MemtoReg;
    logic              ID_EX_Branch;
    logic [CNT_W-1:0]  BubbleCount;

    // Decode side: drives the ID instruction, observes the stage.
    modport master (
        output IF_ID_RegisterRn1, IF_ID_RegisterRm2, IF_ID_RegisterRd, IF_ID_UsesRm,
        output ID_ReadData1, ID_ReadData2, ID_SignExtImm, ID_ALUOp,
        output ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemtoReg, ID_Branch,
        output Flush,
        input  Stall, ID_EX_Valid,
        input  ID_EX_RegisterRn1, ID_EX_RegisterRm2, ID_EX_RegisterRd,
        input  ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm, ID_EX_ALUOp,
        input  ID_EX_ALUSrc, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_RegWrite,
        input  ID_EX_MemtoReg, ID_EX_Branch, BubbleCount
    );

    modport slave (
        input  IF_ID_RegisterRn1, IF_ID_RegisterRm2, IF_ID_RegisterRd, IF_ID_UsesRm,
        input  ID_ReadData1, ID_ReadData2, ID_SignExtImm, ID_ALUOp,
        input  ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemtoReg, ID_Branch,
        input  Flush,
        output Stall, ID_EX_Valid,
        output ID_EX_RegisterRn1, ID_EX_RegisterRm2, ID_EX_RegisterRd,
        output ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm, ID_EX_ALUOp,
        output ID_EX_ALUSrc, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_RegWrite,
        output ID_EX_MemtoReg, ID_EX_Branch, BubbleCount
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection: inserts one bubble
// per dependent load, flushes on taken branches, counts bubbles (saturating).
module id_ex_stage #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);
    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic              valid;
        logic [4:0]        rn1;
        logic [4:0]        rm2;
        logic [4:0]        rd;
        logic [DATA_W-1:0] readData1;
        logic [DATA_W-1:0] readData2;
        logic [DATA_W-1:0] signExtImm;
        logic [1:0]        aluOp;
        logic              aluSrc;
        logic              memRead;
        logic              memWrite;
        logic              regWrite;
        logic              memtoReg;
        logic              branch;
    } exReg_t;

    // Bubble and reset share one encoding: XZR register numbers keep forwarding inert.
    function automatic exReg_t bubbleReg();
        exReg_t b;
        b     = '0;
        b.rn1 = XZR;
        b.rm2 = XZR;
        b.rd  = XZR;
        return b;
    endfunction

    exReg_t           exQ;
    exReg_t           exD;
    exReg_t           captured;
    logic [CNT_W-1:0] bubbleCountQ;
    logic [CNT_W-1:0] bubbleCountD;
    logic             hazard;
    logic             stallInt;

    always_comb begin
        captured            = '0;
        captured.valid      = 1'b1;
        captured.rn1        = bus.IF_ID_RegisterRn1;
        captured.rm2        = bus.IF_ID_RegisterRm2;
        captured.rd         = bus.IF_ID_RegisterRd;
        captured.readData1  = bus.ID_ReadData1;
        captured.readData2  = bus.ID_ReadData2;
        captured.signExtImm = bus.ID_SignExtImm;
        captured.aluOp      = bus.ID_ALUOp;
        captured.aluSrc     = bus.ID_ALUSrc;
        captured.memRead    = bus.ID_MemRead;
        captured.memWrite   = bus.ID_MemWrite;
        captured.regWrite   = bus.ID_RegWrite;
        captured.memtoReg   = bus.ID_MemtoReg;
        captured.branch     = bus.ID_Branch;
    end

    // Load in EX whose destination the ID instruction reads; a flush overrides it.
    always_comb begin
        hazard   = exQ.valid && exQ.memRead && (exQ.rd != XZR) &&
                   ((exQ.rd == bus.IF_ID_RegisterRn1) ||
                    (bus.IF_ID_UsesRm && (exQ.rd == bus.IF_ID_RegisterRm2)));
        stallInt = hazard && !bus.Flush;
    end

    always_comb begin
        exD          = captured;
        bubbleCountD = bubbleCountQ;
        if (bus.Flush) begin
            exD = bubbleReg();
        end else if (stallInt) begin
            exD = bubbleReg();
            if (bubbleCountQ != {CNT_W{1'b1}}) begin
                bubbleCountD = bubbleCountQ + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exQ          <= bubbleReg();
            bubbleCountQ <= '0;
        end else begin
            exQ          <= exD;
            bubbleCountQ <= bubbleCountD;
        end
    end

    assign bus.Stall             = stallInt;
    assign bus.ID_EX_Valid       = exQ.valid;
    assign bus.ID_EX_RegisterRn1 = exQ.rn1;
    assign bus.ID_EX_RegisterRm2 = exQ.rm2;
    assign bus.ID_EX_RegisterRd  = exQ.rd;
    assign bus.ID_EX_ReadData1   = exQ.readData1;
    assign bus.ID_EX_ReadData2   = exQ.readData2;
    assign bus.ID_EX_SignExtImm  = exQ.signExtImm;
    assign bus.ID_EX_ALUOp       = exQ.aluOp;
    assign bus.ID_EX_ALUSrc      = exQ.aluSrc;
    assign bus.ID_EX_MemRead     = exQ.memRead;
    assign bus.ID_EX_MemWrite    = exQ.memWrite;
    assign bus.ID_EX_RegWrite    = exQ.regWrite;
    assign bus.ID_EX_MemtoReg    = exQ.memtoReg;
    assign bus.ID_EX_Branch      = exQ.branch;
    assign bus.BubbleCount       = bubbleCountQ;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, reset/saturation sequences,
// and random stimulus against a behavioural pipeline model.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(64), .CNT_W(16)) bus ();
    id_ex_stage_if #(.DATA_W(64), .CNT_W(2))  busS ();

    id_ex_stage #(.DATA_W(64), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
    id_ex_stage #(.DATA_W(64), .CNT_W(2))  dutS (.clk(clk), .reset(reset), .bus(busS.slave));

    // Narrow-counter instance sees the identical instruction stream.
    assign busS.IF_ID_RegisterRn1 = bus.IF_ID_RegisterRn1;
    assign busS.IF_ID_RegisterRm2 = bus.IF_ID_RegisterRm2;
    assign busS.IF_ID_RegisterRd  = bus.IF_ID_RegisterRd;
    assign busS.IF_ID_UsesRm      = bus.IF_ID_UsesRm;
    assign busS.ID_ReadData1      = bus.ID_ReadData1;
    assign busS.ID_ReadData2      = bus.ID_ReadData2;
    assign busS.ID_SignExtImm     = bus.ID_SignExtImm;
    assign busS.ID_ALUOp          = bus.ID_ALUOp;
    assign busS.ID_ALUSrc         = bus.ID_ALUSrc;
    assign busS.ID_MemRead        = bus.ID_MemRead;
    assign busS.ID_MemWrite       = bus.ID_MemWrite;
    assign busS.ID_RegWrite       = bus.ID_RegWrite;
    assign busS.ID_MemtoReg       = bus.ID_MemtoReg;
    assign busS.ID_Branch         = bus.ID_Branch;
    assign busS.Flush             = bus.Flush;

    typedef struct {
        logic [4:0]  rn, rm, rd;
        logic        usesRm;
        logic [63:0] d1, d2, imm;
        logic [1:0]  aluOp;
        logic        aluSrc, memRead, memWrite, regWrite, memtoReg, branch;
        logic        flush;
    } in_t;

    typedef struct {
        logic        valid;
        logic [4:0]  rn, rm, rd;
        logic [63:0] d1, d2, imm;
        logic [1:0]  aluOp;
        logic        aluSrc, memRead, memWrite, regWrite, memtoReg, branch;
    } stage_t;

    typedef struct {
        in_t         in;
        logic        expStall, expValid;
        logic [4:0]  expRd, expRn1;
        logic        expRegWrite;
        logic [63:0] expD1;
        int          expBub;
    } vec_t;

    int passCount = 0;
    int totalCount = 0;
    vec_t tbl[$];
    stage_t mdl;
    longint unsigned mCount;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCount++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else passCount++;
    endtask

    function automatic in_t mkIn(int rn, int rm, int rd, bit usesRm, bit memRead, bit regWrite,
                                 logic [63:0] d1, bit flush);
        in_t v;
        v.rn = 5'(rn); v.rm = 5'(rm); v.rd = 5'(rd); v.usesRm = usesRm;
        v.d1 = d1; v.d2 = d1 + 64'd1; v.imm = d1 + 64'd2;
        v.aluOp = memRead ? 2'b00 : 2'b10;
        v.aluSrc = memRead; v.memRead = memRead; v.memWrite = 1'b0;
        v.regWrite = regWrite; v.memtoReg = memRead; v.branch = 1'b0;
        v.flush = flush;
        return v;
    endfunction

    function automatic vec_t mkVec(in_t v, bit st, bit vl, int rd, int rn1, bit rw, logic [63:0] d1, int bub);
        vec_t r;
        r.in = v; r.expStall = st; r.expValid = vl; r.expRd = 5'(rd); r.expRn1 = 5'(rn1);
        r.expRegWrite = rw; r.expD1 = d1; r.expBub = bub;
        return r;
    endfunction

    task automatic drive(input in_t v);
        bus.IF_ID_RegisterRn1 = v.rn;
        bus.IF_ID_RegisterRm2 = v.rm;
        bus.IF_ID_RegisterRd  = v.rd;
        bus.IF_ID_UsesRm      = v.usesRm;
        bus.ID_ReadData1      = v.d1;
        bus.ID_ReadData2      = v.d2;
        bus.ID_SignExtImm     = v.imm;
        bus.ID_ALUOp          = v.aluOp;
        bus.ID_ALUSrc         = v.aluSrc;
        bus.ID_MemRead        = v.memRead;
        bus.ID_MemWrite       = v.memWrite;
        bus.ID_RegWrite       = v.regWrite;
        bus.ID_MemtoReg       = v.memtoReg;
        bus.ID_Branch         = v.branch;
        bus.Flush             = v.flush;
    endtask

    function automatic stage_t bubbleStage();
        stage_t s;
        s.valid = 1'b0; s.rn = 5'd31; s.rm = 5'd31; s.rd = 5'd31;
        s.d1 = '0; s.d2 = '0; s.imm = '0; s.aluOp = 2'b00;
        s.aluSrc = 1'b0; s.memRead = 1'b0; s.memWrite = 1'b0;
        s.regWrite = 1'b0; s.memtoReg = 1'b0; s.branch = 1'b0;
        return s;
    endfunction

    function automatic longint unsigned satTo(longint unsigned c, longint unsigned m);
        return (c > m) ? m : c;
    endfunction

    function automatic logic [4:0] pickReg();
        int r;
        r = $urandom_range(0, 9);
        return (r > 7) ? 5'd31 : 5'(r);
    endfunction

    function automatic in_t rndIn();
        in_t v;
        v.rn = pickReg(); v.rm = pickReg(); v.rd = pickReg();
        v.usesRm = 1'($urandom_range(0, 1));
        v.d1 = {$urandom, $urandom}; v.d2 = {$urandom, $urandom}; v.imm = {$urandom, $urandom};
        v.aluOp = 2'($urandom_range(0, 3));
        v.aluSrc = 1'($urandom_range(0, 1));
        v.memRead = ($urandom_range(0, 9) < 4);
        v.memWrite = 1'($urandom_range(0, 1));
        v.regWrite = 1'($urandom_range(0, 1));
        v.memtoReg = 1'($urandom_range(0, 1));
        v.branch = 1'($urandom_range(0, 1));
        v.flush = ($urandom_range(0, 9) == 0);
        return v;
    endfunction

    task automatic checkState(input string tag, input stage_t e, input longint unsigned cnt);
        check({tag, "_valid"},  64'(bus.ID_EX_Valid),       64'(e.valid));
        check({tag, "_rn1"},    64'(bus.ID_EX_RegisterRn1), 64'(e.rn));
        check({tag, "_rm2"},    64'(bus.ID_EX_RegisterRm2), 64'(e.rm));
        check({tag, "_rd"},     64'(bus.ID_EX_RegisterRd),  64'(e.rd));
        check({tag, "_data1"},  bus.ID_EX_ReadData1,        e.d1);
        check({tag, "_data2"},  bus.ID_EX_ReadData2,        e.d2);
        check({tag, "_imm"},    bus.ID_EX_SignExtImm,       e.imm);
        check({tag, "_aluop"},  64'(bus.ID_EX_ALUOp),       64'(e.aluOp));
        check({tag, "_ctrl"},
              64'({bus.ID_EX_ALUSrc, bus.ID_EX_MemRead, bus.ID_EX_MemWrite,
                   bus.ID_EX_RegWrite, bus.ID_EX_MemtoReg, bus.ID_EX_Branch}),
              64'({e.aluSrc, e.memRead, e.memWrite, e.regWrite, e.memtoReg, e.branch}));
        check({tag, "_bub16"},  64'(bus.BubbleCount),  64'(satTo(cnt, 65535)));
        check({tag, "_bub2"},   64'(busS.BubbleCount), 64'(satTo(cnt, 3)));
    endtask

    initial begin
        in_t v;
        logic expStall;
        int satExp[4];

        // Directed table: inputs presented for one cycle, stall checked
        // mid-cycle, captured register contents checked after the edge.
        tbl.push_back(mkVec(mkIn( 1,  2,  3, 1, 0, 1, 64'h10, 0), 0, 1,  3,  1, 1, 64'h10, 0));
        tbl.push_back(mkVec(mkIn( 1,  0,  5, 0, 1, 1, 64'h20, 0), 0, 1,  5,  1, 1, 64'h20, 0));
        tbl.push_back(mkVec(mkIn( 5,  2,  6, 1, 0, 1, 64'h30, 0), 1, 0, 31, 31, 0, 64'h0,  1));
        tbl.push_back(mkVec(mkIn( 5,  2,  6, 1, 0, 1, 64'h30, 0), 0, 1,  6,  5, 1, 64'h30, 1));
        tbl.push_back(mkVec(mkIn( 2,  0, 31, 0, 1, 1, 64'h40, 0), 0, 1, 31,  2, 1, 64'h40, 1));
        tbl.push_back(mkVec(mkIn(31, 31,  8, 1, 0, 1, 64'h50, 0), 0, 1,  8, 31, 1, 64'h50, 1));
        tbl.push_back(mkVec(mkIn( 1,  0,  7, 0, 1, 1, 64'h60, 0), 0, 1,  7,  1, 1, 64'h60, 1));
        tbl.push_back(mkVec(mkIn( 9,  7, 10, 0, 0, 1, 64'h70, 0), 0, 1, 10,  9, 1, 64'h70, 1));
        tbl.push_back(mkVec(mkIn( 1,  0, 11, 0, 1, 1, 64'h80, 0), 0, 1, 11,  1, 1, 64'h80, 1));
        tbl.push_back(mkVec(mkIn(11,  3, 12, 1, 0, 1, 64'h90, 1), 0, 0, 31, 31, 0, 64'h0,  1));
        tbl.push_back(mkVec(mkIn(11,  3, 12, 1, 0, 1, 64'h90, 0), 0, 1, 12, 11, 1, 64'h90, 1));
        tbl.push_back(mkVec(mkIn( 1,  0, 13, 0, 1, 1, 64'hA0, 0), 0, 1, 13,  1, 1, 64'hA0, 1));
        tbl.push_back(mkVec(mkIn( 4, 13, 14, 1, 0, 1, 64'hB0, 0), 1, 0, 31, 31, 0, 64'h0,  2));
        tbl.push_back(mkVec(mkIn( 4, 13, 14, 1, 0, 1, 64'hB0, 0), 0, 1, 14,  4, 1, 64'hB0, 2));

        reset = 1'b1;
        drive(mkIn(0, 0, 0, 0, 0, 0, 64'h0, 0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkState("reset", bubbleStage(), 0);
        check("reset_stall", 64'(bus.Stall), 64'(0));

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            @(negedge clk);
            check($sformatf("vec%0d_stall", i), 64'(bus.Stall), 64'(tbl[i].expStall));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 64'(bus.ID_EX_Valid),       64'(tbl[i].expValid));
            check($sformatf("vec%0d_rd", i),    64'(bus.ID_EX_RegisterRd),  64'(tbl[i].expRd));
            check($sformatf("vec%0d_rn1", i),   64'(bus.ID_EX_RegisterRn1), 64'(tbl[i].expRn1));
            check($sformatf("vec%0d_rw", i),    64'(bus.ID_EX_RegWrite),    64'(tbl[i].expRegWrite));
            check($sformatf("vec%0d_d1", i),    bus.ID_EX_ReadData1,        tbl[i].expD1);
            check($sformatf("vec%0d_bub", i),   64'(bus.BubbleCount),       64'(tbl[i].expBub));
        end

        // Reset asserted while a load-use stall is active.
        drive(mkIn(1, 0, 5, 0, 1, 1, 64'hC0, 0));
        @(posedge clk); #1;
        drive(mkIn(5, 0, 6, 0, 0, 1, 64'hD0, 0));
        reset = 1'b1;
        @(negedge clk);
        check("rststall_stall_before", 64'(bus.Stall), 64'(1));
        @(posedge clk); #1;
        reset = 1'b0;
        check("rststall_valid", 64'(bus.ID_EX_Valid),      64'(0));
        check("rststall_rd",    64'(bus.ID_EX_RegisterRd), 64'(31));
        check("rststall_bub",   64'(bus.BubbleCount),      64'(0));
        @(negedge clk);
        check("rststall_stall_after", 64'(bus.Stall), 64'(0));
        @(posedge clk); #1;

        // Four load-use hazards: 2-bit counter saturates at 3.
        satExp[0] = 1; satExp[1] = 2; satExp[2] = 3; satExp[3] = 3;
        for (int k = 0; k < 4; k++) begin
            drive(mkIn(2, 0, 5, 0, 1, 1, 64'hE0, 0));
            @(posedge clk); #1;
            drive(mkIn(5, 1, 9, 1, 0, 1, 64'hF0, 0));
            @(negedge clk);
            check($sformatf("sat%0d_stall", k), 64'(bus.Stall), 64'(1));
            @(posedge clk); #1;
            check($sformatf("sat%0d_bub2", k),  64'(busS.BubbleCount), 64'(satExp[k]));
            check($sformatf("sat%0d_bub16", k), 64'(bus.BubbleCount),  64'(k + 1));
        end

        // Random stimulus against the behavioural model.
        reset = 1'b1;
        @(posedge clk); #1;
        mdl = bubbleStage();
        mCount = 0;
        for (int n = 0; n < 400; n++) begin
            v = rndIn();
            reset = ($urandom_range(0, 49) == 0);
            drive(v);
            @(negedge clk);
            expStall = mdl.valid && mdl.memRead && (mdl.rd != 5'd31) &&
                       ((mdl.rd == v.rn) || (v.usesRm && (mdl.rd == v.rm))) && !v.flush;
            check($sformatf("rnd%0d_stall", n), 64'(bus.Stall), 64'(expStall));
            checkState($sformatf("rnd%0d", n), mdl, mCount);
            @(posedge clk);
            if (reset) begin
                mdl = bubbleStage();
                mCount = 0;
            end else if (v.flush) begin
                mdl = bubbleStage();
            end else if (expStall) begin
                mdl = bubbleStage();
                mCount++;
            end else begin
                mdl.valid = 1'b1; mdl.rn = v.rn; mdl.rm = v.rm; mdl.rd = v.rd;
                mdl.d1 = v.d1; mdl.d2 = v.d2; mdl.imm = v.imm; mdl.aluOp = v.aluOp;
                mdl.aluSrc = v.aluSrc; mdl.memRead = v.memRead; mdl.memWrite = v.memWrite;
                mdl.regWrite = v.regWrite; mdl.memtoReg = v.memtoReg; mdl.branch = v.branch;
            end
            #1;
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule
